// File: rtl/controle_drone_grade.sv
// controle_drone_grade: drone movement and collision core.
// Keeps the drone (x,y) on a LARGURA x ALTURA grid. Control edges become
// single grid steps, and each target cell is checked against the obstacle
// map. The core also manages lives, including a post-hit invulnerability
// window, and reports venceu/perdeu.
// Optional feature macro: AUTO_REPEAT_EN (held controls re-trigger a step
// every REPEAT_CICLOS cycles). Without it, each press gives exactly one step.
module controle_drone_grade #(
    parameter  int LARGURA       = 16,
    parameter  int ALTURA        = 8,
    parameter  int VIDAS_MAX     = 7,
    parameter  int INVULN_CICLOS = 1000,
    parameter  int REPEAT_CICLOS = 250,
    localparam int WX            = $clog2(LARGURA),
    localparam int WY            = $clog2(ALTURA),
    localparam int WV            = $clog2(VIDAS_MAX + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       iniciar,
    input  logic [WV-1:0]              vidas_iniciais,
    input  logic [1:0]                 controle_vertical,
    input  logic [1:0]                 controle_horizontal,
    input  logic [LARGURA*ALTURA-1:0]  mapa_obstaculos,
    output logic [WX-1:0]              posicao_x,
    output logic [WY-1:0]              posicao_y,
    output logic [WV-1:0]              vidas,
    output logic                       colisao,
    output logic                       invulneravel,
    output logic                       venceu,
    output logic                       perdeu,
    output logic [2:0]                 db_estado
);

    localparam int WT = $clog2(INVULN_CICLOS + 1);
    localparam int WM = $clog2(LARGURA * ALTURA);

    typedef enum logic [2:0] {
        PARADO       = 3'd0,
        ATIVO        = 3'd1,
        INVULNERAVEL = 3'd2,
        VENCEU       = 3'd3,
        PERDEU       = 3'd4
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [WX-1:0]   x_q, x_d;
    logic [WY-1:0]   y_q, y_d;
    logic [WV-1:0]   vidas_q, vidas_d;
    logic [WT-1:0]   timer_q, timer_d;
    logic            colisao_q, colisao_d;
    logic [1:0]      prev_v_q, prev_h_q;

    logic            trig_v_s, trig_h_s;
    logic [WX-1:0]   alvo_x_s;
    logic [WY-1:0]   alvo_y_s;
    logic [WM-1:0]   alvo_idx_s;
    logic            moveu_s, obst_s, ativo_s, passo_ok_s, bateu_s, ganhou_s;

    // 01 and 10 are commands; 00 and 11 mean "no command"
    function automatic logic ctrl_valido(input logic [1:0] c);
        return (c == 2'b01) || (c == 2'b10);
    endfunction

    // Loaded lives are forced into 1..VIDAS_MAX
    function automatic logic [WV-1:0] limita_vidas(input logic [WV-1:0] v);
        logic [WV-1:0] r;
        if (v == '0) begin
            r = WV'(1);
        end else if ({1'b0, v} > (WV+1)'(VIDAS_MAX)) begin
            r = WV'(VIDAS_MAX);
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Last control code per axis, tracked in every state so a control held
    // before a run starts cannot fire until released
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_v_q <= 2'b00;
            prev_h_q <= 2'b00;
        end else begin
            prev_v_q <= controle_vertical;
            prev_h_q <= controle_horizontal;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int WR = $clog2(REPEAT_CICLOS + 1);
    logic [WR-1:0] rep_v_q, rep_v_d, rep_h_q, rep_h_d;

    // Step triggers: a new code fires at once; a held code fires again every REPEAT_CICLOS
    always_comb begin
        trig_v_s = 1'b0;
        rep_v_d  = '0;
        if (!ctrl_valido(controle_vertical)) begin
            trig_v_s = 1'b0;
            rep_v_d  = '0;
        end else if ((controle_vertical != prev_v_q) || (rep_v_q == WR'(REPEAT_CICLOS))) begin
            trig_v_s = 1'b1;
            rep_v_d  = WR'(1);
        end else begin
            trig_v_s = 1'b0;
            rep_v_d  = rep_v_q + WR'(1);
        end
        trig_h_s = 1'b0;
        rep_h_d  = '0;
        if (!ctrl_valido(controle_horizontal)) begin
            trig_h_s = 1'b0;
            rep_h_d  = '0;
        end else if ((controle_horizontal != prev_h_q) || (rep_h_q == WR'(REPEAT_CICLOS))) begin
            trig_h_s = 1'b1;
            rep_h_d  = WR'(1);
        end else begin
            trig_h_s = 1'b0;
            rep_h_d  = rep_h_q + WR'(1);
        end
    end

    // Per-axis hold counters for auto-repeat
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rep_v_q <= '0;
            rep_h_q <= '0;
        end else begin
            rep_v_q <= rep_v_d;
            rep_h_q <= rep_h_d;
        end
    end
`else
    // Step triggers: only a none -> valid transition produces a step
    always_comb begin
        trig_v_s = ctrl_valido(controle_vertical)   && !ctrl_valido(prev_v_q);
        trig_h_s = ctrl_valido(controle_horizontal) && !ctrl_valido(prev_h_q);
    end
`endif

    // Target cell for this cycle; a component that would leave the grid is dropped
    always_comb begin
        alvo_x_s = x_q;
        alvo_y_s = y_q;
        if (trig_h_s && (controle_horizontal == 2'b01) && (x_q != WX'(LARGURA - 1))) begin
            alvo_x_s = x_q + WX'(1);
        end else if (trig_h_s && (controle_horizontal == 2'b10) && (x_q != '0)) begin
            alvo_x_s = x_q - WX'(1);
        end else begin
            alvo_x_s = x_q;
        end
        if (trig_v_s && (controle_vertical == 2'b01) && (y_q != WY'(ALTURA - 1))) begin
            alvo_y_s = y_q + WY'(1);
        end else if (trig_v_s && (controle_vertical == 2'b10) && (y_q != '0)) begin
            alvo_y_s = y_q - WY'(1);
        end else begin
            alvo_y_s = y_q;
        end
        alvo_idx_s = WM'(alvo_y_s) * WM'(LARGURA) + WM'(alvo_x_s);
    end

    // Only an actual move is checked; an obstacle under the drone is ignored
    assign obst_s     = mapa_obstaculos[alvo_idx_s];
    assign moveu_s    = (alvo_x_s != x_q) || (alvo_y_s != y_q);
    assign ativo_s    = (estado_q == ATIVO) || (estado_q == INVULNERAVEL);
    assign passo_ok_s = ativo_s && moveu_s && !obst_s;
    assign bateu_s    = ativo_s && moveu_s && obst_s;
    assign ganhou_s   = passo_ok_s && (alvo_x_s == WX'(LARGURA - 1));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= PARADO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic; a win takes priority over timer expiry
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            PARADO, VENCEU, PERDEU: begin
                if (iniciar) estado_d = ATIVO;
                else         estado_d = estado_q;
            end
            ATIVO: begin
                if (ganhou_s)                            estado_d = VENCEU;
                else if (bateu_s && (vidas_q <= WV'(1))) estado_d = PERDEU;
                else if (bateu_s)                        estado_d = INVULNERAVEL;
                else                                     estado_d = ATIVO;
            end
            INVULNERAVEL: begin
                if (ganhou_s)                   estado_d = VENCEU;
                else if (timer_q <= WT'(1))     estado_d = ATIVO;
                else                            estado_d = INVULNERAVEL;
            end
            default: estado_d = PARADO;
        endcase
    end

    // Position, lives and invulnerability timer updates
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        vidas_d   = vidas_q;
        timer_d   = timer_q;
        colisao_d = bateu_s;
        case (estado_q)
            PARADO, VENCEU, PERDEU: begin
                if (iniciar) begin
                    x_d     = '0;
                    y_d     = '0;
                    vidas_d = limita_vidas(vidas_iniciais);
                end else begin
                    x_d     = x_q;
                    y_d     = y_q;
                    vidas_d = vidas_q;
                end
            end
            ATIVO: begin
                if (passo_ok_s) begin
                    x_d = alvo_x_s;
                    y_d = alvo_y_s;
                end else if (bateu_s) begin
                    vidas_d = (vidas_q == '0) ? '0 : vidas_q - WV'(1);
                    timer_d = WT'(INVULN_CICLOS);
                end else begin
                    x_d = x_q;
                    y_d = y_q;
                end
            end
            INVULNERAVEL: begin
                if (passo_ok_s) begin
                    x_d = alvo_x_s;
                    y_d = alvo_y_s;
                end else begin
                    x_d = x_q;
                    y_d = y_q;
                end
                timer_d = (timer_q != '0) ? timer_q - WT'(1) : '0;
            end
            default: begin
                x_d       = '0;
                y_d       = '0;
                vidas_d   = '0;
                timer_d   = '0;
                colisao_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q       <= '0;
            y_q       <= '0;
            vidas_q   <= '0;
            timer_q   <= '0;
            colisao_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            vidas_q   <= vidas_d;
            timer_q   <= timer_d;
            colisao_q <= colisao_d;
        end
    end

    // Output decode from registered state
    always_comb begin
        posicao_x    = x_q;
        posicao_y    = y_q;
        vidas        = vidas_q;
        colisao      = colisao_q;
        invulneravel = (estado_q == INVULNERAVEL);
        venceu       = (estado_q == VENCEU);
        perdeu       = (estado_q == PERDEU);
        db_estado    = estado_q;
    end

endmodule

// File: tb/tb_controle_drone_grade.sv
// Self-checking bench for controle_drone_grade with a behavioural game model.
module tb_controle_drone_grade;

    localparam int L    = 16;
    localparam int A    = 8;
    localparam int VMAX = 5;
    localparam int INV  = 20;
    localparam int REP  = 250;
`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           iniciar = 1'b0;
    logic [2:0]     vidas_iniciais = 3'd0;
    logic [1:0]     cv = 2'b00;
    logic [1:0]     ch = 2'b00;
    logic [L*A-1:0] mapa = '0;
    logic [3:0]     posicao_x;
    logic [2:0]     posicao_y;
    logic [2:0]     vidas;
    logic           colisao, invulneravel, venceu, perdeu;
    logic [2:0]     db_estado;
    logic [16:0]    obs;

    int checks = 0;
    int errors = 0;

    // model state: st 0 idle, 1 active, 2 invulnerable, 3 won, 4 lost
    int m_x, m_y, m_v, m_st, m_t, m_lv, m_lh;
    bit m_col;
    logic [1:0] m_pv, m_ph;

    always #5 clock = ~clock;

    assign obs = {posicao_x, posicao_y, vidas, colisao, invulneravel, venceu, perdeu, db_estado};

    controle_drone_grade #(
        .LARGURA(L), .ALTURA(A), .VIDAS_MAX(VMAX), .INVULN_CICLOS(INV), .REPEAT_CICLOS(REP)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .vidas_iniciais(vidas_iniciais),
        .controle_vertical(cv), .controle_horizontal(ch), .mapa_obstaculos(mapa),
        .posicao_x(posicao_x), .posicao_y(posicao_y), .vidas(vidas), .colisao(colisao),
        .invulneravel(invulneravel), .venceu(venceu), .perdeu(perdeu), .db_estado(db_estado)
    );

    function automatic bit ok(input logic [1:0] c);
        return (c == 2'b01) || (c == 2'b10);
    endfunction

    function automatic logic [16:0] model_vec();
        return {4'(m_x), 3'(m_y), 3'(m_v), m_col, (m_st == 2), (m_st == 3), (m_st == 4), 3'(m_st)};
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_v = 0; m_st = 0; m_t = 0; m_col = 1'b0;
        m_pv = 2'b00; m_ph = 2'b00; m_lv = 0; m_lh = 0;
    endtask

    // one clock edge of the game rules, using the inputs present before the edge
    task automatic model_step();
        int lv_cur, lh_cur, nx, ny, old;
        bit trv, trh, moved, blocked;
        if (!reset) begin
            model_reset();
            return;
        end
        lh_cur = (ok(ch) && ch == m_ph) ? m_lh + 1 : 0;
        lv_cur = (ok(cv) && cv == m_pv) ? m_lv + 1 : 0;
        trh = AR ? (ok(ch) && (lh_cur % REP) == 0) : (ok(ch) && !ok(m_ph));
        trv = AR ? (ok(cv) && (lv_cur % REP) == 0) : (ok(cv) && !ok(m_pv));
        m_lh = lh_cur; m_lv = lv_cur; m_ph = ch; m_pv = cv;
        m_col = 1'b0;
        old = m_st;
        if (old == 0 || old == 3 || old == 4) begin
            if (iniciar) begin
                m_st = 1; m_x = 0; m_y = 0;
                m_v = (vidas_iniciais == 0) ? 1 : ((vidas_iniciais > VMAX) ? VMAX : int'(vidas_iniciais));
            end
        end else begin
            nx = m_x; ny = m_y;
            if (trh) nx = (ch == 2'b01) ? m_x + 1 : m_x - 1;
            if (trv) ny = (cv == 2'b01) ? m_y + 1 : m_y - 1;
            if (nx < 0 || nx > L - 1) nx = m_x;
            if (ny < 0 || ny > A - 1) ny = m_y;
            moved   = (nx != m_x) || (ny != m_y);
            blocked = moved && mapa[ny * L + nx];
            m_col   = blocked;
            if (moved && !blocked) begin
                m_x = nx; m_y = ny;
            end
            if (moved && !blocked && nx == L - 1) begin
                m_st = 3;
            end else if (blocked && old == 1) begin
                m_v = m_v - 1;
                if (m_v == 0) m_st = 4;
                else begin m_st = 2; m_t = INV; end
            end else if (old == 2) begin
                if (m_t == 1) m_st = 1;
                else m_t = m_t - 1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        tick();
        reset = 1'b1;
    endtask

    task automatic start(input int v);
        vidas_iniciais = 3'(v);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    task automatic press(input logic [1:0] v, input logic [1:0] h);
        cv = v; ch = h;
        tick();
        cv = 2'b00; ch = 2'b00;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        #2;
        checks++;
        if (obs !== 17'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", obs); end
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (db_estado !== 3'd0) begin errors++; $display("FAIL reset_idle: got %0d expected 0", db_estado); end
    endtask

    task automatic test_start_clamp();
        int vi_tab[3] = '{0, 7, 3};
        int ex_tab[3] = '{1, VMAX, 3};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            start(vi_tab[i]);
            checks++;
            if (vidas !== 3'(ex_tab[i]) || db_estado !== 3'd1) begin
                errors++;
                $display("FAIL start_clamp[%0d]: got vidas=%0d st=%0d expected vidas=%0d st=1", i, vidas, db_estado, ex_tab[i]);
            end
        end
    endtask

    task automatic test_win();
        do_reset();
        mapa = '0;
        start(3);
        for (int i = 0; i < 7; i++) press(2'b00, 2'b01);
        checks++;
        if (posicao_x !== 4'd7 || venceu !== 1'b0) begin errors++; $display("FAIL win_mid: got x=%0d venceu=%0d expected x=7 venceu=0", posicao_x, venceu); end
        for (int i = 0; i < 8; i++) press(2'b00, 2'b01);
        checks++;
        if (posicao_x !== 4'd15 || venceu !== 1'b1 || db_estado !== 3'd3) begin
            errors++; $display("FAIL win_reach: got x=%0d venceu=%0d st=%0d expected 15 1 3", posicao_x, venceu, db_estado);
        end
        press(2'b00, 2'b10);
        press(2'b01, 2'b00);
        checks++;
        if (posicao_x !== 4'd15 || posicao_y !== 3'd0 || db_estado !== 3'd3) begin
            errors++; $display("FAIL win_hold: got x=%0d y=%0d st=%0d expected 15 0 3", posicao_x, posicao_y, db_estado);
        end
    endtask

    task automatic test_collision();
        int seen;
        do_reset();
        mapa = '0;
        mapa[1] = 1'b1;
        start(3);
        ch = 2'b01;
        tick();
        checks++;
        if (posicao_x !== 4'd0 || colisao !== 1'b1 || vidas !== 3'd2 || invulneravel !== 1'b1) begin
            errors++; $display("FAIL hit_first: got x=%0d col=%0d vidas=%0d inv=%0d expected 0 1 2 1", posicao_x, colisao, vidas, invulneravel);
        end
        seen = 1;
        ch = 2'b00;
        tick();
        if (invulneravel) seen++;
        checks++;
        if (colisao !== 1'b0) begin errors++; $display("FAIL hit_pulse: got col=%0d expected 0", colisao); end
        ch = 2'b01;
        tick();
        if (invulneravel) seen++;
        checks++;
        if (colisao !== 1'b1 || vidas !== 3'd2 || db_estado !== 3'd2 || posicao_x !== 4'd0) begin
            errors++; $display("FAIL hit_invuln: got col=%0d vidas=%0d st=%0d x=%0d expected 1 2 2 0", colisao, vidas, db_estado, posicao_x);
        end
        ch = 2'b00;
        for (int i = 0; i < 100 && invulneravel; i++) begin
            tick();
            if (invulneravel) seen++;
        end
        checks++;
        if (seen !== INV || invulneravel !== 1'b0 || db_estado !== 3'd1) begin
            errors++; $display("FAIL invuln_window: got %0d cycles st=%0d expected %0d cycles st=1", seen, db_estado, INV);
        end
    endtask

    task automatic test_lose_edges();
        do_reset();
        mapa = '0;
        mapa[1] = 1'b1;
        start(1);
        ch = 2'b01;
        tick();
        ch = 2'b00;
        checks++;
        if (vidas !== 3'd0 || perdeu !== 1'b1 || db_estado !== 3'd4 || posicao_x !== 4'd0) begin
            errors++; $display("FAIL lose: got vidas=%0d perdeu=%0d st=%0d x=%0d expected 0 1 4 0", vidas, perdeu, db_estado, posicao_x);
        end
        tick();
        mapa = '0;
        start(2);
        press(2'b10, 2'b00);
        checks++;
        if (posicao_y !== 3'd0 || db_estado !== 3'd1) begin errors++; $display("FAIL edge_down: got y=%0d st=%0d expected 0 1", posicao_y, db_estado); end
        cv = 2'b01; ch = 2'b01;
        tick();
        checks++;
        if (posicao_x !== 4'd1 || posicao_y !== 3'd1) begin errors++; $display("FAIL diagonal: got (%0d,%0d) expected (1,1)", posicao_x, posicao_y); end
        cv = 2'b00; ch = 2'b00;
        tick();
        for (int i = 0; i < 6; i++) press(2'b01, 2'b00);
        checks++;
        if (posicao_y !== 3'd7) begin errors++; $display("FAIL climb: got y=%0d expected 7", posicao_y); end
        press(2'b01, 2'b00);
        checks++;
        if (posicao_y !== 3'd7 || posicao_x !== 4'd1) begin errors++; $display("FAIL edge_up: got (%0d,%0d) expected (1,7)", posicao_x, posicao_y); end
    endtask

    task automatic test_midrun_reset();
        do_reset();
        mapa = '0;
        start(3);
        for (int i = 0; i < 5; i++) press(2'b00, 2'b01);
        checks++;
        if (posicao_x !== 4'd5) begin errors++; $display("FAIL pre_reset: got x=%0d expected 5", posicao_x); end
        ch = 2'b01;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (posicao_x !== 4'd0 || posicao_y !== 3'd0 || vidas !== 3'd0 || db_estado !== 3'd0) begin
            errors++; $display("FAIL async_reset: got x=%0d y=%0d vidas=%0d st=%0d expected all 0", posicao_x, posicao_y, vidas, db_estado);
        end
        ch = 2'b00;
        model_reset();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_hold();
        int expx;
        do_reset();
        mapa = '0;
        start(3);
        ch = 2'b01;
        repeat (500) tick();
        ch = 2'b00;
        tick();
        expx = AR ? 2 : 1;
        checks++;
        if (posicao_x !== 4'(expx) || m_x != expx) begin
            errors++; $display("FAIL hold_repeat: got x=%0d model=%0d expected %0d", posicao_x, m_x, expx);
        end
    endtask

    task automatic test_random();
        do_reset();
        mapa = '0;
        start(4);
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                for (int b = 0; b < L * A; b++) mapa[b] = ($urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 2) == 0) ch = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) cv = 2'($urandom_range(0, 3));
            iniciar = ($urandom_range(0, 19) == 0);
            vidas_iniciais = 3'($urandom_range(0, 7));
            tick();
            checks++;
            if (obs !== model_vec()) begin
                errors++; $display("FAIL random_cycle %0d: got %h expected %h", c, obs, model_vec());
            end
        end
        iniciar = 1'b0; cv = 2'b00; ch = 2'b00;
    endtask

    initial begin
        test_reset();
        test_start_clamp();
        test_win();
        test_collision();
        test_lose_edges();
        test_midrun_reset();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
